branch_sequencer: RTL and testbench
===================================

// Module: branch_sequencer
// PURPOSE
//  Sequences branch resolution around the target-address generator for the PA-RISC pipeline.
//  Captures a decoded branch in ID together with its target address (TA) and return address (R).
//  Waits for the condition result, then steers the PC mux, the delay-slot nullify, the link
//  write and the stall.
//  Sits between decode, the TA/return-address logic, the EX condition unit and the fetch PC mux.
// PARAMETERS
//  PC_W     8  width of PC, TA and R
//  STAT_W  16  width of the optional branch statistics counters
// PORTS
//  clk           in   1     pipeline clock
//  reset         in   1     asynchronous, active-high reset
//  br_valid      in   1     branch decoded in ID this cycle (ignored while busy=1)
//  br_uncond     in   1     branch is unconditional (B/BL); no condition wait
//  br_link       in   1     branch writes return address (BL)
//  br_n          in   1     nullify bit of the instruction
//  br_backward   in   1     displacement sign bit (1 = backward)
//  ta            in   PC_W  target address from the TA generator, valid with br_valid
//  ret_addr      in   PC_W  return address (B_PC+8), valid with br_valid
//  cond_valid    in   1     EX condition result valid
//  cond_true     in   1     condition evaluated true
//  stall_in      in   1     downstream stall; FSM holds state, outputs frozen
//  pc_sel        out  2     00 = PC+4, 01 = target_pc, 10 = hold
//  target_pc     out  PC_W  registered redirect address
//  nullify_next  out  1     nullify the delay-slot instruction, 1-cycle pulse
//  link_we       out  1     return-address register write, 1-cycle pulse
//  link_data     out  PC_W  captured ret_addr
//  stall_out     out  1     stall fetch/decode while waiting on a condition
//  busy          out  1     FSM not in IDLE
// BEHAVIOUR
//  - Reset (async, immediate): state=IDLE, pc_sel=00, target_pc=0, link_data=0, all 1-bit outputs 0.
//  - Capture: in IDLE, br_valid=1 and stall_in=0 registers ta, ret_addr, br_link, br_n,
//    br_backward and br_uncond.
//  - FSM states: IDLE, WAIT_COND, DELAY, REDIRECT.
//    - IDLE -> DELAY: br_valid and br_uncond, taken=1.
//    - IDLE -> WAIT_COND: br_valid and not br_uncond.
//    - WAIT_COND: stall_out=1 and pc_sel=10 until cond_valid. On cond_valid, taken=cond_true,
//      then -> DELAY (same edge). If cond_valid arrives in the capture cycle, it is not sampled;
//      it is sampled from the next cycle.
//    - DELAY: the delay slot issues with pc_sel=00.
//      nullify_next=1 iff br_n and (br_uncond or (taken and backward) or (!taken and !backward)).
//      link_we=1 iff br_link (asserted even if not taken; BL is always unconditional).
//      -> REDIRECT if taken, else -> IDLE.
//    - REDIRECT: pc_sel=01, target_pc=captured TA for exactly one cycle, then -> IDLE.
//  - Latency: unconditional branch redirects 2 cycles after capture. Conditional branch
//    redirects 2 cycles after cond_valid.
//  - stall_in=1 in any state: no transition, no capture, pulses deferred (not dropped, not
//    repeated).
//  - br_valid while busy: ignored; decode must hold it, and stall_out/busy tell it to.
//    Back-to-back branch: a new br_valid is accepted in the cycle the FSM is back in IDLE.
//  - Arithmetic: none on addresses. TA and R pass through unmodified, PC_W bits, no wrap handling.
//  - Reset mid-operation: pending redirect, nullify and link are discarded.
// CONFIGURATION
//  - BRANCH_SEQ_STATS_EN defined: adds outputs stat_taken[STAT_W] and stat_not_taken[STAT_W].
//    Each increments once on the DELAY-entry edge, saturates at all-ones and clears on reset.
//  - BRANCH_SEQ_STATS_EN undefined: the ports and counters are absent; behaviour is otherwise
//    identical.
// STRUCTURE
//  - branch_pkg holds: state encoding (IDLE=2'd0, WAIT_COND=2'd1, DELAY=2'd2, REDIRECT=2'd3)
//    and PC_SEL_SEQ/PC_SEL_TGT/PC_SEL_HOLD constants.
//  - Sub-module branch_nullify_rule: combinational nullify decision
//    (n, uncond, taken, backward -> nullify).
// TESTING
//  - Unconditional BL, ta=8'h40, ret=8'h18, n=0 -> cycle+1: link_we=1, link_data=18, nullify=0;
//    cycle+2: pc_sel=01, target_pc=40.
//  - Conditional, backward, n=1, cond_true after 3 cycles -> stall_out=1 for 3 cycles,
//    then nullify_next=1, then redirect to ta.
//  - Conditional, forward, n=1, cond_true=0 -> nullify_next=1, no redirect, back to IDLE,
//    pc_sel stays 00.
//  - stall_in=1 held 2 cycles during DELAY -> pulses appear once, after stall_in drops.
//  - reset asserted in WAIT_COND -> outputs 0 immediately; later cond_valid has no effect.
//  - With BRANCH_SEQ_STATS_EN: 3 taken and 2 not-taken -> stat_taken=3, stat_not_taken=2.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared encodings for the branch sequencer: FSM states and PC mux select codes.
package branch_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_COND = 2'd1,
        DELAY     = 2'd2,
        REDIRECT  = 2'd3
    } state_t;

    localparam logic [1:0] PC_SEL_SEQ  = 2'b00;
    localparam logic [1:0] PC_SEL_TGT  = 2'b01;
    localparam logic [1:0] PC_SEL_HOLD = 2'b10;

endpackage

// File: rtl/branch_nullify_rule.sv
// Delay-slot nullify decision: the ,n bit cancels the slot for unconditional branches,
// taken backward branches and not-taken forward branches.
module branch_nullify_rule (
    input  logic n,
    input  logic uncond,
    input  logic taken,
    input  logic backward,
    output logic nullify
);

    always_comb begin
        nullify = n & (uncond | (taken & backward) | (~taken & ~backward));
    end

endmodule

// File: rtl/branch_sequencer.sv
// Branch resolution sequencer: captures a decoded branch, waits for the condition and drives
// PC mux, delay-slot nullify, link write and stall. Optional counters under BRANCH_SEQ_STATS_EN.
module branch_sequencer
    import branch_pkg::*;
#(
    parameter int PC_W   = 8,
    parameter int STAT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              br_valid,
    input  logic              br_uncond,
    input  logic              br_link,
    input  logic              br_n,
    input  logic              br_backward,
    input  logic [PC_W-1:0]   ta,
    input  logic [PC_W-1:0]   ret_addr,
    input  logic              cond_valid,
    input  logic              cond_true,
    input  logic              stall_in,
    output logic [1:0]        pc_sel,
    output logic [PC_W-1:0]   target_pc,
    output logic              nullify_next,
    output logic              link_we,
    output logic [PC_W-1:0]   link_data,
    output logic              stall_out,
    output logic              busy
`ifdef BRANCH_SEQ_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_taken,
    output logic [STAT_W-1:0] stat_not_taken
`endif
);

    state_t          state, next_state;
    logic [PC_W-1:0] ta_q;
    logic            link_q, n_q, backward_q, uncond_q, taken_q;
    logic            capture, delay_active, delay_entry, taken_in, load_target;
    logic            rule_nullify;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Pulses are gated by stall_in so a stalled DELAY defers them rather than repeating them.
    always_comb begin
        next_state   = state;
        capture      = 1'b0;
        delay_active = 1'b0;
        pc_sel       = PC_SEL_SEQ;
        stall_out    = 1'b0;
        case (state)
            IDLE: begin
                if (br_valid && !stall_in) begin
                    capture    = 1'b1;
                    next_state = br_uncond ? DELAY : WAIT_COND;
                end
            end
            WAIT_COND: begin
                pc_sel    = PC_SEL_HOLD;
                stall_out = 1'b1;
                if (cond_valid && !stall_in) begin
                    next_state = DELAY;
                end
            end
            DELAY: begin
                delay_active = !stall_in;
                if (!stall_in) begin
                    next_state = taken_q ? REDIRECT : IDLE;
                end
            end
            REDIRECT: begin
                pc_sel = PC_SEL_TGT;
                if (!stall_in) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        taken_in    = (state == IDLE) ? br_uncond : cond_true;
        delay_entry = (next_state == DELAY) && (state != DELAY);
        load_target = (state == DELAY) && (next_state == REDIRECT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ta_q       <= '0;
            link_data  <= '0;
            link_q     <= 1'b0;
            n_q        <= 1'b0;
            backward_q <= 1'b0;
            uncond_q   <= 1'b0;
            taken_q    <= 1'b0;
            target_pc  <= '0;
        end else begin
            if (capture) begin
                ta_q       <= ta;
                link_data  <= ret_addr;
                link_q     <= br_link;
                n_q        <= br_n;
                backward_q <= br_backward;
                uncond_q   <= br_uncond;
            end
            if (delay_entry) begin
                taken_q <= taken_in;
            end
            if (load_target) begin
                target_pc <= ta_q;
            end
        end
    end

    branch_nullify_rule u_nullify_rule (
        .n        (n_q),
        .uncond   (uncond_q),
        .taken    (taken_q),
        .backward (backward_q),
        .nullify  (rule_nullify)
    );

    always_comb begin
        nullify_next = delay_active & rule_nullify;
        link_we      = delay_active & link_q;
        busy         = (state != IDLE);
    end

`ifdef BRANCH_SEQ_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_taken     <= '0;
            stat_not_taken <= '0;
        end else if (delay_entry) begin
            if (taken_in) begin
                if (stat_taken != '1) begin
                    stat_taken <= stat_taken + {{(STAT_W-1){1'b0}}, 1'b1};
                end
            end else begin
                if (stat_not_taken != '1) begin
                    stat_not_taken <= stat_not_taken + {{(STAT_W-1){1'b0}}, 1'b1};
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_sequencer.sv
// Scoreboard bench for branch_sequencer; exercises stats ports when BRANCH_SEQ_STATS_EN is defined.
module tb_branch_sequencer;

    localparam int PC_W   = 8;
    localparam int STAT_W = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              br_valid, br_uncond, br_link, br_n, br_backward;
    logic [PC_W-1:0]   ta, ret_addr;
    logic              cond_valid, cond_true, stall_in;
    logic [1:0]        pc_sel;
    logic [PC_W-1:0]   target_pc, link_data;
    logic              nullify_next, link_we, stall_out, busy;
`ifdef BRANCH_SEQ_STATS_EN
    logic [STAT_W-1:0] stat_taken, stat_not_taken;
`endif

    branch_sequencer #(.PC_W(PC_W), .STAT_W(STAT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .br_valid     (br_valid),
        .br_uncond    (br_uncond),
        .br_link      (br_link),
        .br_n         (br_n),
        .br_backward  (br_backward),
        .ta           (ta),
        .ret_addr     (ret_addr),
        .cond_valid   (cond_valid),
        .cond_true    (cond_true),
        .stall_in     (stall_in),
        .pc_sel       (pc_sel),
        .target_pc    (target_pc),
        .nullify_next (nullify_next),
        .link_we      (link_we),
        .link_data    (link_data),
        .stall_out    (stall_out),
        .busy         (busy)
`ifdef BRANCH_SEQ_STATS_EN
        ,
        .stat_taken     (stat_taken),
        .stat_not_taken (stat_not_taken)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic            nul;
        logic            lnk;
        logic [PC_W-1:0] ld;
        logic            taken;
        logic [PC_W-1:0] tgt;
    } exp_t;

    exp_t            sb[$];
    int              n_checks = 0;
    int              n_errors = 0;
    int              stall_cnt = 0;
    int              exp_taken_cnt = 0;
    int              exp_not_taken_cnt = 0;
    logic            redir_pending = 1'b0;
    logic            redir_taken;
    logic [PC_W-1:0] redir_ta;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Monitor: a DELAY cycle is busy with pc_sel=00; the cycle after it shows the redirect (or not).
    always @(negedge clk) begin
        if (reset) begin
            redir_pending = 1'b0;
        end else begin
            if (stall_out) stall_cnt++;
            if (redir_pending && !stall_in) begin
                check_eq("REDIR_SEL", {30'd0, pc_sel}, redir_taken ? 32'd1 : 32'd0);
                if (redir_taken) check_eq("REDIR_TA", {24'd0, target_pc}, {24'd0, redir_ta});
                redir_pending = 1'b0;
            end else if (busy && pc_sel == 2'b00) begin
                if (stall_in) begin
                    check_eq("STALL_NUL", {31'd0, nullify_next}, 32'd0);
                    check_eq("STALL_LNK", {31'd0, link_we}, 32'd0);
                end else begin
                    check_eq("SB_PENDING", {31'd0, sb.size() != 0}, 32'd1);
                    if (sb.size() != 0) begin
                        exp_t e;
                        e = sb.pop_front();
                        check_eq("DLY_NUL", {31'd0, nullify_next}, {31'd0, e.nul});
                        check_eq("DLY_LNK", {31'd0, link_we}, {31'd0, e.lnk});
                        if (e.lnk) check_eq("DLY_LDATA", {24'd0, link_data}, {24'd0, e.ld});
                        redir_pending = 1'b1;
                        redir_taken   = e.taken;
                        redir_ta      = e.tgt;
                    end
                end
            end else if (link_we || nullify_next) begin
                check_eq("STRAY_PULSE", {30'd0, link_we, nullify_next}, 32'd0);
            end
        end
    end

    // Drives one branch, held until accepted; pushes the expected DELAY/redirect outcome.
    task automatic do_branch(input logic uncond, input logic link, input logic n, input logic bw,
                             input logic [PC_W-1:0] t, input logic [PC_W-1:0] r,
                             input logic ct, input int wait_cyc, input logic early_cond);
        int   k;
        exp_t e;
        logic tk;
        br_valid = 1'b1; br_uncond = uncond; br_link = link; br_n = n; br_backward = bw;
        ta = t; ret_addr = r;
        if (early_cond) begin
            cond_valid = 1'b1;
            cond_true  = ~ct;
        end
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while ((busy || stall_in) && k < 50);
        check_eq("CAPTURE_TO", {31'd0, k < 50}, 32'd1);
        @(posedge clk);
        #1;
        br_valid = 1'b0; cond_valid = 1'b0;
        tk = uncond ? 1'b1 : ct;
        e.taken = tk;
        e.tgt   = t;
        e.lnk   = link;
        e.ld    = r;
        e.nul   = n && (uncond || (tk == bw));
        sb.push_back(e);
        if (tk) exp_taken_cnt++; else exp_not_taken_cnt++;
        if (!uncond) begin
            repeat (wait_cyc - 1) begin
                @(posedge clk);
                #1;
            end
            cond_valid = 1'b1;
            cond_true  = ct;
            @(posedge clk);
            #1;
            cond_valid = 1'b0;
        end
    endtask

    initial begin
        int s0;
        reset = 1'b1;
        br_valid = 0; br_uncond = 0; br_link = 0; br_n = 0; br_backward = 0;
        ta = '0; ret_addr = '0; cond_valid = 0; cond_true = 0; stall_in = 0;
        #2;
        check_eq("RST_PCSEL", {30'd0, pc_sel}, 32'd0);
        check_eq("RST_BUSY", {31'd0, busy}, 32'd0);
        check_eq("RST_TGT", {24'd0, target_pc}, 32'd0);
        check_eq("RST_OUT1", {28'd0, nullify_next, link_we, stall_out, busy}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset while waiting on a condition discards the branch.
        br_valid = 1'b1; br_uncond = 0; br_link = 0; br_n = 1; ta = 8'h77; ret_addr = 8'h55;
        @(posedge clk);
        #1;
        br_valid = 1'b0;
        @(posedge clk);
        #1;
        check_eq("WAIT_STALL", {31'd0, stall_out}, 32'd1);
        check_eq("WAIT_PCSEL", {30'd0, pc_sel}, 32'd2);
        reset = 1'b1;
        #1;
        check_eq("MIDRST_BUSY", {31'd0, busy}, 32'd0);
        check_eq("MIDRST_STALL", {31'd0, stall_out}, 32'd0);
        check_eq("MIDRST_PCSEL", {30'd0, pc_sel}, 32'd0);
        check_eq("MIDRST_LDATA", {24'd0, link_data}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        cond_valid = 1'b1; cond_true = 1'b1;
        @(posedge clk);
        #1;
        cond_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("POSTRST_BUSY", {31'd0, busy}, 32'd0);

        // Unconditional BL: link at +1, redirect at +2.
        do_branch(1, 1, 0, 0, 8'h40, 8'h18, 1, 1, 0);
        check_eq("BL_LNK", {31'd0, link_we}, 32'd1);
        check_eq("BL_LDATA", {24'd0, link_data}, 32'h18);
        check_eq("BL_NUL", {31'd0, nullify_next}, 32'd0);
        @(posedge clk);
        #1;
        check_eq("BL_PCSEL", {30'd0, pc_sel}, 32'd1);
        check_eq("BL_TGT", {24'd0, target_pc}, 32'h40);

        // Conditional backward ,n taken after 3 cycles.
        s0 = stall_cnt;
        do_branch(0, 0, 1, 1, 8'h20, 8'h64, 1, 3, 0);
        check_eq("COND_STALLCNT", stall_cnt - s0, 32'd3);

        // Conditional forward ,n not taken.
        do_branch(0, 0, 1, 0, 8'h90, 8'h30, 0, 2, 0);

        // Unconditional B ,n with stall_in held two cycles in DELAY.
        do_branch(1, 0, 1, 0, 8'hA4, 8'h0C, 1, 1, 0);
        stall_in = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        stall_in = 1'b0;

        // cond_valid in the capture cycle is ignored; the later result is not taken.
        do_branch(0, 0, 1, 1, 8'h3C, 8'h10, 0, 2, 1);

`ifdef BRANCH_SEQ_STATS_EN
        check_eq("STAT_TAKEN3", {16'd0, stat_taken}, 32'd3);
        check_eq("STAT_NTAKEN2", {16'd0, stat_not_taken}, 32'd2);
`endif

        // Back-to-back branches: each is driven while the previous one is still busy.
        for (int i = 0; i < 6; i++) begin
            logic u;
            u = 1'($urandom_range(0, 1));
            do_branch(u, u & 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
                      1'($urandom_range(0, 1)), int'($urandom_range(1, 3)), 0);
        end

        repeat (6) @(posedge clk);
        #1;
        check_eq("SB_DRAIN", sb.size(), 32'd0);
        check_eq("REDIR_DRAIN", {31'd0, redir_pending}, 32'd0);
        check_eq("END_BUSY", {31'd0, busy}, 32'd0);
`ifdef BRANCH_SEQ_STATS_EN
        check_eq("STAT_TAKEN", {16'd0, stat_taken}, exp_taken_cnt);
        check_eq("STAT_NTAKEN", {16'd0, stat_not_taken}, exp_not_taken_cnt);
`endif
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL TIMEOUT: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
